// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice, registered carry,
// LSB-first, with registered sum/cout/overflow and a one-cycle done pulse.
module serial_adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aSh_q, bSh_q, work_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;

  logic             bitSum, bitCarry;
  logic [WIDTH-1:0] work_d;

  always_comb begin
    bitSum   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    bitCarry = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
    work_d   = work_q >> 1;
    work_d[WIDTH-1] = bitSum;
  end

  // On the last bit carry_q is the carry into the MSB (the initial carry when
  // WIDTH=1), so overflow needs no separate carry_into_msb register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          aSh_q   <= aSh_q >> 1;
          bSh_q   <= bSh_q >> 1;
          carry_q <= bitCarry;
          work_q  <= work_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            sum_q   <= work_d;
            cout_q  <= bitCarry;
            ovf_q   <= carry_q ^ bitCarry;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            aSh_q   <= a;
            bSh_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Self-checking bench for serial_adder_nbit: WIDTH=8 and WIDTH=1 instances
// compared against an arithmetic reference model.
module tb_serial_adder_nbit;

  logic       clk, rst;
  logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start1, sub1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int failures = 0;
  logic [63:0] lastSum8 = '0;
  logic [63:0] lastSum1 = '0;

  serial_adder_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));

  serial_adder_nbit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                input logic s, input logic ci,
                                output logic [63:0] sm, output logic co, output logic ov);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned ua = av & mask;
    longint unsigned ub = (s ? ~bv : bv) & mask;
    longint unsigned c = s ? 1 : (ci ? 1 : 0);
    longint unsigned tot = ua + ub + c;
    longint half = longint'(64'd1 << (w - 1));
    longint sa = (ua >= half) ? longint'(ua) - 2 * half : longint'(ua);
    longint sb = (ub >= half) ? longint'(ub) - 2 * half : longint'(ub);
    longint st = sa + sb + longint'(c);
    sm = tot & mask;
    co = ((tot >> w) & 1) != 0;
    ov = (st > half - 1) || (st < -half);
  endfunction

  task automatic applyStimulus(input bit one, input logic [7:0] av, input logic [7:0] bv,
                               input logic s, input logic ci);
    int w = one ? 1 : 8;
    logic [63:0] es;
    logic ec, eo;
    model(w, {56'b0, av}, {56'b0, bv}, s, ci, es, ec, eo);
    @(negedge clk);
    if (one) begin a1 = av[0]; b1 = bv[0]; sub1 = s; cin1 = ci; start1 = 1'b1; end
    else     begin a8 = av;    b8 = bv;    sub8 = s; cin8 = ci; start8 = 1'b1; end
    @(posedge clk); #1;
    start1 = 1'b0; start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
    sub8 = 1'($urandom); cin8 = 1'($urandom); sub1 = 1'($urandom); cin1 = 1'($urandom);
    for (int k = 0; k < w; k++) begin
      checkOutput("run_busy", one ? busy1 : busy8, 1);
      checkOutput("run_done", one ? done1 : done8, 0);
      checkOutput("run_sum_hold", one ? {63'b0, sum1} : {56'b0, sum8}, one ? lastSum1 : lastSum8);
      @(posedge clk); #1;
    end
    checkOutput("end_done", one ? done1 : done8, 1);
    checkOutput("end_busy", one ? busy1 : busy8, 0);
    checkOutput("end_sum", one ? {63'b0, sum1} : {56'b0, sum8}, es);
    checkOutput("end_cout", one ? cout1 : cout8, ec);
    checkOutput("end_ovf", one ? ovf1 : ovf8, eo);
    if (one) lastSum1 = es; else lastSum8 = es;
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    start8 = 1'b0; start1 = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      checkOutput("idle_done8", done8, 0);
      checkOutput("idle_done1", done1, 0);
    end
  endtask

  initial begin
    logic [7:0]  pa, pb;
    logic        ps, pc;
    logic [63:0] es;
    logic        ec, eo;

    rst = 1'b1;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    pa = '0; pb = '0; ps = 0; pc = 0;
    #12;
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    checkOutput("rst_sum", {56'b0, sum8}, 0);
    checkOutput("rst_cout", cout8, 0);
    checkOutput("rst_ovf", ovf8, 0);
    @(negedge clk); rst = 1'b0;

    applyStimulus(0, 8'h5A, 8'h3C, 0, 0);
    idleCycles(2);
    applyStimulus(0, 8'hFF, 8'h01, 0, 0);
    applyStimulus(0, 8'h7F, 8'h00, 0, 1);
    applyStimulus(0, 8'h10, 8'h20, 1, 1);
    applyStimulus(0, 8'h80, 8'h01, 1, 0);
    idleCycles(1);

    // Start held high with fresh operands every cycle: accepted every 9 edges.
    @(negedge clk);
    start8 = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    for (int n = 0; n < 36; n++) begin
      @(posedge clk);
      if (n % 9 == 0) begin pa = a8; pb = b8; ps = sub8; pc = cin8; end
      #1;
      checkOutput("hs_done", done8, (n % 9 == 8) ? 1 : 0);
      checkOutput("hs_busy", busy8, (n % 9 == 8) ? 0 : 1);
      if (n % 9 == 8) begin
        model(8, {56'b0, pa}, {56'b0, pb}, ps, pc, es, ec, eo);
        checkOutput("hs_sum", {56'b0, sum8}, es);
        checkOutput("hs_cout", cout8, ec);
        checkOutput("hs_ovf", ovf8, eo);
        lastSum8 = es;
      end else begin
        checkOutput("hs_sum_hold", {56'b0, sum8}, lastSum8);
      end
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    end
    idleCycles(2);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 0; cin8 = 0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy8, 0);
    checkOutput("mid_rst_done", done8, 0);
    checkOutput("mid_rst_sum", {56'b0, sum8}, 0);
    checkOutput("mid_rst_cout", cout8, 0);
    checkOutput("mid_rst_ovf", ovf8, 0);
    lastSum8 = '0; lastSum1 = '0;
    @(negedge clk); rst = 1'b0;
    idleCycles(10);
    applyStimulus(0, 8'h01, 8'h02, 0, 0);

    applyStimulus(1, 8'h01, 8'h01, 0, 1);
    applyStimulus(1, 8'h01, 8'h01, 0, 0);
    idleCycles(1);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      applyStimulus(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
